// File: rtl/wb_pkg.sv
// Shared widths and the buffered writeback entry type for the writeback arbiter.
// Optional forwarding ports are enabled by defining WB_BYPASS_EN.
package wb_pkg;

    localparam int unsigned REG_ADDR_W         = 5;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 2;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] regAddr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of multdiv results with per-entry invalidation by destination match.
// With WB_BYPASS_EN defined, the raw slots and read pointer are exported for forwarding.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  push,
    input  wb_entry_t             pushEntry,
    input  logic                  pop,
    input  logic                  invEn,
    input  logic [REG_ADDR_W-1:0] invReg,
    output wb_entry_t             headEntry,
    output logic [CNT_W-1:0]      count
`ifdef WB_BYPASS_EN
    ,
    output wb_entry_t             slots [DEPTH],
    output logic [PTR_W-1:0]      rdPtrQ
`endif
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] cnt;

    // A push in the same cycle overrides invalidation of its slot; the pushed entry is fresh.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (invEn && (mem[i].regAddr == invReg)) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (push) begin
                mem[wrPtr] <= pushEntry;
                wrPtr      <= PTR_W'(wrPtr + PTR_W'(1));
            end
            if (pop) begin
                rdPtr <= PTR_W'(rdPtr + PTR_W'(1));
            end
            cnt <= CNT_W'(cnt + CNT_W'(push) - CNT_W'(pop));
        end
    end

    assign headEntry = mem[rdPtr];
    assign count     = cnt;

`ifdef WB_BYPASS_EN
    assign slots  = mem;
    assign rdPtrQ = rdPtr;
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Regfile writeback arbiter: ALU has priority, multdiv results queue in wb_fifo.
// Define WB_BYPASS_EN to add read-port forwarding of pending writes.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_reg,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  md_ready,
    output logic                  ctrl_writeEn,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]     data_writeReg,
    output logic [CNT_W-1:0]      fifo_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegA,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegB,
    output logic                  fwd_hitA,
    output logic                  fwd_hitB,
    output logic [DATA_W-1:0]     fwd_dataA,
    output logic [DATA_W-1:0]     fwd_dataB
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    wb_entry_t headEntry;
    wb_entry_t mdEntry;
    wb_entry_t selEntry;
    logic      selValid;
    logic      mdAccept;
    logic      mdDrop;
    logic      fifoPush;
    logic      fifoPop;
    logic      doWrite;

`ifdef WB_BYPASS_EN
    wb_entry_t        slots [FIFO_DEPTH];
    logic [PTR_W-1:0] rdPtrQ;
    logic [PTR_W-1:0] idx;
`endif

    assign md_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign mdEntry  = '{valid: 1'b1, regAddr: md_reg, data: md_data};

    // Write-port selection: ALU, else buffer head, else bypass an accepted md result.
    always_comb begin
        selValid = 1'b0;
        selEntry = '0;
        fifoPop  = 1'b0;
        mdAccept = md_valid && md_ready;
        mdDrop   = (md_reg == '0) || (alu_valid && (md_reg == alu_reg));
        if (alu_valid) begin
            selValid = 1'b1;
            selEntry = '{valid: 1'b1, regAddr: alu_reg, data: alu_data};
        end else if (fifo_count != '0) begin
            selValid = 1'b1;
            selEntry = headEntry;
            fifoPop  = 1'b1;
        end else if (mdAccept) begin
            selValid = 1'b1;
            selEntry = mdEntry;
        end
        fifoPush = mdAccept && !mdDrop && (alu_valid || (fifo_count != '0));
        doWrite  = selValid && selEntry.valid && (selEntry.regAddr != '0);
    end

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .ctrl_reset_n(ctrl_reset_n),
        .push        (fifoPush),
        .pushEntry   (mdEntry),
        .pop         (fifoPop),
        .invEn       (alu_valid),
        .invReg      (alu_reg),
        .headEntry   (headEntry),
        .count       (fifo_count)
`ifdef WB_BYPASS_EN
        ,
        .slots       (slots),
        .rdPtrQ      (rdPtrQ)
`endif
    );

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ctrl_writeEn  <= 1'b0;
            ctrl_writeReg <= '0;
            data_writeReg <= '0;
        end else begin
            ctrl_writeEn  <= doWrite;
            ctrl_writeReg <= doWrite ? selEntry.regAddr : '0;
            data_writeReg <= doWrite ? selEntry.data : '0;
        end
    end

`ifdef WB_BYPASS_EN
    // Scan buffer oldest to youngest so younger hits win; output register overrides last.
    always_comb begin
        fwd_hitA  = 1'b0;
        fwd_hitB  = 1'b0;
        fwd_dataA = '0;
        fwd_dataB = '0;
        idx       = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            idx = PTR_W'(rdPtrQ + PTR_W'(i));
            if ((CNT_W'(i) < fifo_count) && slots[idx].valid && (slots[idx].regAddr != '0)) begin
                if (slots[idx].regAddr == ctrl_readRegA) begin
                    fwd_hitA  = 1'b1;
                    fwd_dataA = slots[idx].data;
                end
                if (slots[idx].regAddr == ctrl_readRegB) begin
                    fwd_hitB  = 1'b1;
                    fwd_dataB = slots[idx].data;
                end
            end
        end
        if (ctrl_writeEn && (ctrl_writeReg == ctrl_readRegA)) begin
            fwd_hitA  = 1'b1;
            fwd_dataA = data_writeReg;
        end
        if (ctrl_writeEn && (ctrl_writeReg == ctrl_readRegB)) begin
            fwd_hitB  = 1'b1;
            fwd_dataB = data_writeReg;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic against a queue model.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  clock = 1'b0;
    logic                  ctrl_reset_n = 1'b0;
    logic                  alu_valid = 1'b0;
    logic [REG_ADDR_W-1:0] alu_reg = '0;
    logic [DATA_W-1:0]     alu_data = '0;
    logic                  md_valid = 1'b0;
    logic [REG_ADDR_W-1:0] md_reg = '0;
    logic [DATA_W-1:0]     md_data = '0;
    logic                  md_ready;
    logic                  ctrl_writeEn;
    logic [REG_ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0]     data_writeReg;
    logic [CNT_W-1:0]      fifo_count;
`ifdef WB_BYPASS_EN
    logic [REG_ADDR_W-1:0] ctrl_readRegA = '0;
    logic [REG_ADDR_W-1:0] ctrl_readRegB = '0;
    logic                  fwd_hitA, fwd_hitB;
    logic [DATA_W-1:0]     fwd_dataA, fwd_dataB;
`endif

    wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .alu_valid    (alu_valid),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .md_valid     (md_valid),
        .md_reg       (md_reg),
        .md_data      (md_data),
        .md_ready     (md_ready),
        .ctrl_writeEn (ctrl_writeEn),
        .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .fifo_count   (fifo_count)
`ifdef WB_BYPASS_EN
        ,
        .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB),
        .fwd_hitA     (fwd_hitA),
        .fwd_hitB     (fwd_hitB),
        .fwd_dataA    (fwd_dataA),
        .fwd_dataB    (fwd_dataB)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          v;
        int          r;
        int unsigned d;
    } ent_t;

    ent_t        mq[$];
    bit          expWe;
    int          expWr;
    int unsigned expWd;
    int          nChecks = 0;
    int          nPass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Youngest pending write to rd: registered write first, then newest buffered entry.
    task automatic fwdExp(input int rd, output bit hit, output int unsigned d);
        hit = 1'b0;
        d   = 0;
        if (rd == 0) return;
        if (expWe && expWr == rd) begin
            hit = 1'b1;
            d   = expWd;
            return;
        end
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].v && mq[i].r == rd) begin
                hit = 1'b1;
                d   = mq[i].d;
                return;
            end
        end
    endtask

    task automatic modelReset();
        mq.delete();
        expWe = 1'b0;
        expWr = 0;
        expWd = 0;
    endtask

    task automatic cycle(input bit av, input int ar, input int unsigned ad,
                         input bit mv, input int mr, input int unsigned md);
        bit   acc;
        bit   sel;
        ent_t s;
        @(negedge clock);
        alu_valid = av;
        alu_reg   = 5'(ar);
        alu_data  = ad;
        md_valid  = mv;
        md_reg    = 5'(mr);
        md_data   = md;
        #1;
        check("md_ready", 32'(md_ready), 32'(mq.size() < DEPTH));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
`ifdef WB_BYPASS_EN
        begin
            bit          h;
            int unsigned fd;
            fwdExp(int'(ctrl_readRegA), h, fd);
            check("fwd_hitA", 32'(fwd_hitA), 32'(h));
            if (h) check("fwd_dataA", fwd_dataA, fd);
            fwdExp(int'(ctrl_readRegB), h, fd);
            check("fwd_hitB", 32'(fwd_hitB), 32'(h));
            if (h) check("fwd_dataB", fwd_dataB, fd);
        end
`endif
        acc = mv && (mq.size() < DEPTH);
        sel = 1'b0;
        s   = '{v: 1'b0, r: 0, d: 0};
        if (av) begin
            sel = 1'b1;
            s   = '{v: 1'b1, r: ar, d: ad};
            foreach (mq[i]) if (mq[i].r == ar) mq[i].v = 1'b0;
            if (acc && mr != 0 && mr != ar) mq.push_back('{v: 1'b1, r: mr, d: md});
        end else if (mq.size() > 0) begin
            sel = 1'b1;
            s   = mq.pop_front();
            if (acc && mr != 0) mq.push_back('{v: 1'b1, r: mr, d: md});
        end else if (acc) begin
            sel = 1'b1;
            s   = '{v: 1'b1, r: mr, d: md};
        end
        expWe = sel && s.v && s.r != 0;
        expWr = expWe ? s.r : 0;
        expWd = expWe ? s.d : 0;
        @(posedge clock);
        #1;
        check("writeEn", 32'(ctrl_writeEn), 32'(expWe));
        check("writeReg", 32'(ctrl_writeReg), 32'(expWr));
        check("writeData", data_writeReg, expWd);
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        #200000;
        $error("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        modelReset();
        #12;
        check("rst_writeEn", 32'(ctrl_writeEn), 32'd0);
        check("rst_writeReg", 32'(ctrl_writeReg), 32'd0);
        check("rst_writeData", data_writeReg, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_md_ready", 32'(md_ready), 32'd1);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        idle();

        // Single ALU write
        cycle(1'b1, 5, 32'h0000DEAD, 1'b0, 0, 0);
        check("alu_we", 32'(ctrl_writeEn), 32'd1);
        check("alu_reg", 32'(ctrl_writeReg), 32'd5);
        check("alu_data", data_writeReg, 32'h0000DEAD);

        // md buffered behind a 3-cycle ALU stream
        cycle(1'b1, 3, 32'h11, 1'b1, 7, 32'h1234);
        cycle(1'b1, 3, 32'h22, 1'b0, 0, 0);
        cycle(1'b1, 3, 32'h33, 1'b0, 0, 0);
        check("md_buf_count", 32'(fifo_count), 32'd1);
        idle();
        check("md_drain_reg", 32'(ctrl_writeReg), 32'd7);
        check("md_drain_data", data_writeReg, 32'h1234);
        idle();

        // Two buffered, third held until a slot frees; order 10,11,12
        cycle(1'b1, 1, 32'hA1, 1'b1, 10, 32'h100);
        cycle(1'b1, 1, 32'hA2, 1'b1, 11, 32'h200);
        check("full_count", 32'(fifo_count), 32'd2);
        check("full_ready", 32'(md_ready), 32'd0);
        cycle(1'b1, 1, 32'hA3, 1'b1, 12, 32'h300);
        cycle(1'b0, 0, 0, 1'b1, 12, 32'h300);
        check("order1", 32'(ctrl_writeReg), 32'd10);
        cycle(1'b0, 0, 0, 1'b1, 12, 32'h300);
        check("order2", 32'(ctrl_writeReg), 32'd11);
        idle();
        check("order3", 32'(ctrl_writeReg), 32'd12);
        check("order3_data", data_writeReg, 32'h300);

        // WAW: younger ALU write kills buffered md to same register
        cycle(1'b1, 2, 32'h55, 1'b1, 9, 32'h5555);
        cycle(1'b1, 9, 32'hAAAA, 1'b0, 0, 0);
        check("waw_reg", 32'(ctrl_writeReg), 32'd9);
        check("waw_data", data_writeReg, 32'hAAAA);
        idle();
        check("waw_stale_silent", 32'(ctrl_writeEn), 32'd0);
        check("waw_empty", 32'(fifo_count), 32'd0);

        // Same-cycle md to ALU's register is dropped
        cycle(1'b1, 6, 32'h66, 1'b1, 6, 32'h6666);
        idle();

        // Destination zero never writes
        cycle(1'b1, 0, 32'h77, 1'b1, 0, 32'h88);
        check("zero_alu", 32'(ctrl_writeEn), 32'd0);
        cycle(1'b0, 0, 0, 1'b1, 0, 32'h99);
        check("zero_md", 32'(ctrl_writeEn), 32'd0);

`ifdef WB_BYPASS_EN
        // Forwarding from a buffered entry
        cycle(1'b1, 1, 32'h1, 1'b1, 4, 32'hBEEF);
        @(negedge clock);
        ctrl_readRegA = 5'd4;
        ctrl_readRegB = 5'd0;
        #1;
        check("fwdA_hit", 32'(fwd_hitA), 32'd1);
        check("fwdA_data", fwd_dataA, 32'hBEEF);
        check("fwdB_hit", 32'(fwd_hitB), 32'd0);
        idle();
        idle();
`endif

        // Mid-operation reset with two entries buffered
        cycle(1'b1, 1, 32'hB1, 1'b1, 13, 32'h1300);
        cycle(1'b1, 1, 32'hB2, 1'b1, 14, 32'h1400);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        @(negedge clock);
        alu_valid    = 1'b0;
        md_valid     = 1'b0;
        ctrl_reset_n = 1'b0;
        #1;
        check("midrst_writeEn", 32'(ctrl_writeEn), 32'd0);
        check("midrst_writeReg", 32'(ctrl_writeReg), 32'd0);
        check("midrst_writeData", data_writeReg, 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_ready", 32'(md_ready), 32'd1);
        modelReset();
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        idle();
        check("post_rst_nowrite", 32'(ctrl_writeEn), 32'd0);
        idle();

        // Random traffic with a narrow register range to provoke collisions
        for (int n = 0; n < 400; n++) begin
`ifdef WB_BYPASS_EN
            ctrl_readRegA = 5'($urandom_range(0, 7));
            ctrl_readRegB = 5'($urandom_range(0, 7));
`endif
            cycle($urandom_range(0, 9) < 6, int'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom);
        end
        for (int n = 0; n < 4; n++) idle();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning multdiv-result buffer entries (power of two, >=2).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port ctrl_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port alu_valid  input  1  single-cycle-path writeback request.
REQ-005 SHALL have ports alu_reg  input  5 / alu_data  input  32  ALU destination and value.
REQ-006 SHALL have port md_valid  input  1  multdiv completion request.
REQ-007 SHALL have ports md_reg  input  5 / md_data  input  32  multdiv destination and value.
REQ-008 SHALL have port md_ready  output  1  buffer can accept an md request this cycle.
REQ-009 SHALL have ports ctrl_writeEn  output  1 / ctrl_writeReg  output  5 / data_writeReg  output  32  registered drive of the regfile write port.
REQ-010 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  current buffered md entries.

Function
REQ-011 SHALL accept alu requests unconditionally; ALU path never stalls.
REQ-012 SHALL accept an md request only when md_valid and md_ready are both high.
REQ-013 SHALL, per cycle, select one write: live ALU request first, else buffer head, else accepted md request directly (buffer bypassed when empty).
REQ-014 SHALL push an accepted md request into the buffer when not selected directly that cycle.
REQ-015 SHALL register the selected write so ctrl_writeEn/Reg/data appear exactly one cycle after selection; ctrl_writeEn low otherwise.
REQ-016 SHALL discard any request with destination 0; it is accepted but never asserts ctrl_writeEn.
REQ-017 SHALL invalidate every buffered entry whose destination equals a same-cycle ALU destination (WAW: ALU is younger); invalidated entries pop without writing.
REQ-018 SHALL drop a same-cycle md request whose md_reg equals alu_reg (md treated as older).
REQ-019 SHALL drive md_ready = (fifo_count < FIFO_DEPTH), combinational from registered count; a pop in the same cycle does not raise md_ready.
REQ-020 SHALL wrap read/write pointers modulo FIFO_DEPTH; simultaneous push and pop when full keeps count unchanged only if md_ready was high (cannot occur when full).
REQ-021 SHALL preserve md completion order among buffered entries.

Reset
REQ-022 SHALL on ctrl_reset_n low immediately clear ctrl_writeEn, ctrl_writeReg, data_writeReg to 0, pointers and fifo_count to 0, md_ready to 1.
REQ-023 SHALL discard all buffered entries when reset asserts mid-operation; no write issues in the first cycle after release.

Configuration
REQ-024 SHALL honour macro WB_BYPASS_EN: when defined, add inputs ctrl_readRegA/ctrl_readRegB (5 each) and outputs fwd_hitA/fwd_hitB (1) and fwd_dataA/fwd_dataB (32) reporting the youngest pending non-zero-destination write (output register, then buffer, youngest first) matching each read address.
REQ-025 SHALL, when WB_BYPASS_EN is undefined, omit those ports and all comparison logic; core behaviour identical.

Structure
REQ-026 SHALL place REG_ADDR_W=5, DATA_W=32, default FIFO_DEPTH and the wb_entry_t typedef (valid, reg, data) in shared package wb_pkg.
REQ-027 SHALL implement the buffer as sub-module wb_fifo (push, pop, per-entry invalidate by address match, count).

Verification
REQ-028 SHALL cover: alu_valid=1, alu_reg=5, alu_data=32'h0000DEAD -> next cycle ctrl_writeEn=1, ctrl_writeReg=5, data_writeReg=32'h0000DEAD.
REQ-029 SHALL cover: md_valid with md_reg=7, data=32'h1234 while alu writes reg 3 for 3 cycles -> md buffered, fifo_count=1, written to 7 the cycle after ALU stream ends.
REQ-030 SHALL cover: two md requests buffered behind continuous ALU writes -> fifo_count=2, md_ready=0, third md held until a pop, then order 1,2,3 on write port.
REQ-031 SHALL cover: md reg 9 buffered, then ALU writes reg 9 = 32'hAAAA -> only 32'hAAAA reaches reg 9; stale entry pops silently.
REQ-032 SHALL cover: alu_reg=0 and md_reg=0 requests -> ctrl_writeEn never asserted; assert ctrl_reset_n low with 2 entries buffered -> outputs 0, fifo_count=0, md_ready=1 immediately.
REQ-033 SHALL cover with WB_BYPASS_EN: reg 4 buffered with 32'hBEEF, ctrl_readRegA=4 -> fwd_hitA=1, fwd_dataA=32'hBEEF; ctrl_readRegB=0 -> fwd_hitB=0.
